// File: rtl/axis_adder_pkg.sv
// Shared types and helpers for the stream adder subsystem.
// Combinational only: no latency, no backpressure.
// Provides the default operand width, the tid width helper and the lock FSM encodings.
package axis_adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

endpackage

// File: rtl/adder_comb.sv
// Unsigned adder producing a full-width sum with the carry in the MSB.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the output follows the inputs.
module adder_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: pointer register plus a one-hot grant, with an optional forced owner.
// Latency: grant is combinational; the pointer updates on the edge after upd_vld.
// Backpressure: grant is only raised toward a requester whose req bit is set.
module rr_arbiter
    import axis_adder_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic               clk_i,
    input  logic               arstn_i,
    input  logic [NUM_REQ-1:0] req,
    input  logic               hold_vld,
    input  logic [IDW-1:0]     hold_idx,
    input  logic               upd_vld,
    input  logic [IDW-1:0]     upd_idx,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx
);

    logic [IDW-1:0] ptr;
    logic [IDW:0]   cand;
    logic [IDW-1:0] idx;
    logic           found;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ptr <= '0;
        end else if (upd_vld) begin
            ptr <= (upd_idx == IDW'(NUM_REQ - 1)) ? '0 : upd_idx + IDW'(1);
        end
    end

    // Search starts at the pointer and wraps modulo NUM_REQ; first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        idx       = '0;
        if (hold_vld) begin
            if (req[hold_idx]) begin
                grant[hold_idx] = 1'b1;
                grant_idx       = hold_idx;
            end
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = {1'b0, ptr} + (IDW+1)'(k);
                if (cand >= (IDW+1)'(NUM_REQ)) begin
                    cand = cand - (IDW+1)'(NUM_REQ);
                end
                idx = cand[IDW-1:0];
                if (!found && req[idx]) begin
                    found      = 1'b1;
                    grant[idx] = 1'b1;
                    grant_idx  = idx;
                end
            end
        end
    end

endmodule

// File: rtl/axis_adder_arb.sv
// Shares one adder between NUM_REQ AXI-Stream requesters; optional packet lock via AXIS_ADDER_ARB_PKT_LOCK_EN.
// Latency: 1 cycle from accepted beat to m_tvalid_o; 1 beat/cycle while m_tready_i is high.
// Backpressure: a held output (m_tvalid_o & !m_tready_i) drops every s_tready_o bit.
module axis_adder_arb
    import axis_adder_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int NUM_REQ = 2
) (
    input  logic                       clk_i,
    input  logic                       arstn_i,
    input  logic [NUM_REQ-1:0]         s_tvalid_i,
    output logic [NUM_REQ-1:0]         s_tready_o,
    input  logic [NUM_REQ*2*WIDTH-1:0] s_tdata_i,
    input  logic [NUM_REQ-1:0]         s_tlast_i,
    output logic                       m_tvalid_o,
    input  logic                       m_tready_i,
    output logic [WIDTH:0]             m_tdata_o,
    output logic [idw_of(NUM_REQ)-1:0] m_tid_o,
    output logic                       m_tlast_o
);

    localparam int IDW = idw_of(NUM_REQ);

    logic               slot_free;
    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               accept;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               last_sel;
    logic [WIDTH:0]     sum;
    logic               hold_vld;
    logic [IDW-1:0]     hold_idx;
    logic               upd_vld;

    assign slot_free  = !m_tvalid_o || m_tready_i;
    assign s_tready_o = grant & {NUM_REQ{slot_free}};
    assign accept     = |(s_tvalid_i & s_tready_o);

    always_comb begin
        op_a     = '0;
        op_b     = '0;
        last_sel = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (grant_idx == IDW'(r)) begin
                op_a     = s_tdata_i[r*2*WIDTH +: WIDTH];
                op_b     = s_tdata_i[r*2*WIDTH+WIDTH +: WIDTH];
                last_sel = s_tlast_i[r];
            end
        end
    end

    adder_comb #(.WIDTH(WIDTH)) u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (sum)
    );

`ifdef AXIS_ADDER_ARB_PKT_LOCK_EN
    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] owner_nxt;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state <= ST_IDLE;
            owner <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        case (state)
            ST_IDLE: begin
                if (accept && !last_sel) begin
                    state_nxt = ST_LOCKED;
                    owner_nxt = grant_idx;
                end
            end
            ST_LOCKED: begin
                if (accept && last_sel) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Pointer only advances at packet boundaries so a packet is never split.
    assign hold_vld = (state == ST_LOCKED);
    assign hold_idx = owner;
    assign upd_vld  = accept && last_sel;
`else
    assign hold_vld = 1'b0;
    assign hold_idx = '0;
    assign upd_vld  = accept;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
        .clk_i     (clk_i),
        .arstn_i   (arstn_i),
        .req       (s_tvalid_i),
        .hold_vld  (hold_vld),
        .hold_idx  (hold_idx),
        .upd_vld   (upd_vld),
        .upd_idx   (grant_idx),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            m_tvalid_o <= 1'b0;
            m_tdata_o  <= '0;
            m_tid_o    <= '0;
            m_tlast_o  <= 1'b0;
        end else if (slot_free) begin
            m_tvalid_o <= accept;
            if (accept) begin
                m_tdata_o <= sum;
                m_tid_o   <= grant_idx;
                m_tlast_o <= last_sel;
            end
        end
    end

endmodule

// File: tb/tb_axis_adder_arb.sv
// Directed bench for axis_adder_arb with WIDTH=4, NUM_REQ=2; build with AXIS_ADDER_ARB_PKT_LOCK_EN to check the locked ordering.
module tb_axis_adder_arb;

    logic        clk = 1'b0;
    logic        arstn;
    logic [1:0]  s_tvalid;
    logic [1:0]  s_tready;
    logic [15:0] s_tdata;
    logic [1:0]  s_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [4:0]  m_tdata;
    logic [0:0]  m_tid;
    logic        m_tlast;

    int total = 0;
    int bad   = 0;
    int vcycles;

    // Queue entries are {last, b, a}.
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [0:0] out_tid[$];
    logic [4:0] out_dat[$];
    logic       out_last[$];

    axis_adder_arb #(.WIDTH(4), .NUM_REQ(2)) dut (
        .clk_i      (clk),
        .arstn_i    (arstn),
        .s_tvalid_i (s_tvalid),
        .s_tready_o (s_tready),
        .s_tdata_i  (s_tdata),
        .s_tlast_i  (s_tlast),
        .m_tvalid_o (m_tvalid),
        .m_tready_i (m_tready),
        .m_tdata_o  (m_tdata),
        .m_tid_o    (m_tid),
        .m_tlast_o  (m_tlast)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        arstn    = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        q0.delete(); q1.delete();
        out_tid.delete(); out_dat.delete(); out_last.delete();
        vcycles = 0;
        repeat (2) @(negedge clk);
        arstn = 1'b1;
    endtask

    task automatic run(input int ncyc, input logic [31:0] rdy);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            m_tready = (c < 32) ? rdy[c] : 1'b1;
            if (q0.size() > 0) begin
                s_tvalid[0] = 1'b1; s_tdata[7:0] = q0[0][7:0]; s_tlast[0] = q0[0][8];
            end else begin
                s_tvalid[0] = 1'b0; s_tdata[7:0] = '0; s_tlast[0] = 1'b0;
            end
            if (q1.size() > 0) begin
                s_tvalid[1] = 1'b1; s_tdata[15:8] = q1[0][7:0]; s_tlast[1] = q1[0][8];
            end else begin
                s_tvalid[1] = 1'b0; s_tdata[15:8] = '0; s_tlast[1] = 1'b0;
            end
            #1;
            if (m_tvalid) vcycles++;
            if (m_tvalid && m_tready) begin
                out_tid.push_back(m_tid);
                out_dat.push_back(m_tdata);
                out_last.push_back(m_tlast);
            end
            if (s_tvalid[0] && s_tready[0]) void'(q0.pop_front());
            if (s_tvalid[1] && s_tready[1]) void'(q1.pop_front());
        end
        s_tvalid = '0; s_tdata = '0; s_tlast = '0;
    endtask

    task automatic test_reset();
        arstn = 1'b0;
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b0;
        #3;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid: got %0b want 0", m_tvalid); end
        total++; if (m_tdata !== 5'd0) begin bad++; $display("FAIL reset_tdata: got %0d want 0", m_tdata); end
        total++; if (m_tid !== 1'b0) begin bad++; $display("FAIL reset_tid: got %0d want 0", m_tid); end
        total++; if (m_tlast !== 1'b0) begin bad++; $display("FAIL reset_tlast: got %0b want 0", m_tlast); end
        repeat (2) @(negedge clk);
        arstn = 1'b1;
        @(negedge clk); #1;
        total++; if (s_tready !== 2'b00) begin bad++; $display("FAIL reset_tready: got %b want 00", s_tready); end
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_idle_tvalid: got %0b want 0", m_tvalid); end
    endtask

    task automatic test_single();
        do_reset();
        q0.push_back({1'b1, 4'd9, 4'd7});
        run(6, 32'hFFFF_FFFF);
        total++; if (out_dat.size() !== 1) begin bad++; $display("FAIL single_count: got %0d want 1", out_dat.size()); end
        if (out_dat.size() >= 1) begin
            total++; if (out_dat[0] !== 5'd16) begin bad++; $display("FAIL single_data: got %0d want 16", out_dat[0]); end
            total++; if (out_tid[0] !== 1'b0) begin bad++; $display("FAIL single_tid: got %0d want 0", out_tid[0]); end
            total++; if (out_last[0] !== 1'b1) begin bad++; $display("FAIL single_last: got %0b want 1", out_last[0]); end
        end
        total++; if (vcycles !== 1) begin bad++; $display("FAIL single_valid_cycles: got %0d want 1", vcycles); end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back({1'b1, 4'd4, 4'd3});
            q1.push_back({1'b1, 4'd15, 4'd15});
        end
        run(12, 32'hFFFF_FFFF);
        total++; if (out_dat.size() !== 8) begin bad++; $display("FAIL fair_count: got %0d want 8", out_dat.size()); end
        for (int i = 0; i < 8 && i < out_dat.size(); i++) begin
            total++;
            if (out_tid[i] !== 1'(i % 2) || out_dat[i] !== ((i % 2) ? 5'd30 : 5'd7)) begin
                bad++;
                $display("FAIL fair_beat%0d: got tid=%0d data=%0d want tid=%0d data=%0d",
                         i, out_tid[i], out_dat[i], i % 2, (i % 2) ? 30 : 7);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        m_tready = 1'b0;
        s_tvalid = 2'b01; s_tdata = {8'h00, 4'd5, 4'd7}; s_tlast = 2'b01;
        #1;
        total++; if (s_tready !== 2'b01) begin bad++; $display("FAIL bp_first_ready: got %b want 01", s_tready); end
        @(negedge clk);
        s_tvalid = 2'b10; s_tdata = {4'd1, 4'd2, 8'h00}; s_tlast = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (m_tvalid !== 1'b1 || m_tdata !== 5'd12 || m_tid !== 1'b0 || s_tready !== 2'b00) begin
                bad++;
                $display("FAIL bp_hold%0d: got v=%0b data=%0d tid=%0d rdy=%b want v=1 data=12 tid=0 rdy=00",
                         i, m_tvalid, m_tdata, m_tid, s_tready);
            end
            @(negedge clk);
        end
        m_tready = 1'b1;
        #1;
        total++; if (s_tready !== 2'b10) begin bad++; $display("FAIL bp_release_ready: got %b want 10", s_tready); end
        @(negedge clk);
        s_tvalid = '0; s_tdata = '0; s_tlast = '0;
        #1;
        total++;
        if (m_tvalid !== 1'b1 || m_tdata !== 5'd3 || m_tid !== 1'b1) begin
            bad++;
            $display("FAIL bp_next_beat: got v=%0b data=%0d tid=%0d want v=1 data=3 tid=1", m_tvalid, m_tdata, m_tid);
        end
        @(negedge clk); #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %0b want 0", m_tvalid); end
    endtask

    task automatic test_pkt_lock();
        logic [0:0] exp_tid [5];
        int         nexp;
`ifdef AXIS_ADDER_ARB_PKT_LOCK_EN
        exp_tid = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        nexp = 4;
`else
        exp_tid = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        nexp = 5;
`endif
        do_reset();
        q0.push_back({1'b0, 4'd1, 4'd1});
        q0.push_back({1'b0, 4'd2, 4'd2});
        q0.push_back({1'b1, 4'd3, 4'd3});
        q1.push_back({1'b1, 4'd0, 4'd1});
        q1.push_back({1'b1, 4'd0, 4'd1});
        run(12, 32'hFFFF_FFFF);
        total++; if (out_tid.size() !== 5) begin bad++; $display("FAIL lock_count: got %0d want 5", out_tid.size()); end
        for (int i = 0; i < nexp && i < out_tid.size(); i++) begin
            total++;
            if (out_tid[i] !== exp_tid[i]) begin
                bad++;
                $display("FAIL lock_tid%0d: got %0d want %0d", i, out_tid[i], exp_tid[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        m_tready = 1'b0;
        s_tvalid = 2'b01; s_tdata = {8'h00, 4'd1, 4'd1}; s_tlast = 2'b00;
        @(negedge clk);
        s_tvalid = '0; s_tdata = '0;
        #1;
        total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %0b want 1", m_tvalid); end
        arstn = 1'b0;
        #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL mid_async_clear: got %0b want 0", m_tvalid); end
        @(negedge clk);
        arstn = 1'b1;
        m_tready = 1'b1;
        s_tvalid = 2'b10; s_tdata = {4'd3, 4'd4, 8'h00}; s_tlast = 2'b10;
        #1;
        total++; if (s_tready !== 2'b10) begin bad++; $display("FAIL mid_grant: got %b want 10", s_tready); end
        @(negedge clk);
        s_tvalid = '0; s_tdata = '0; s_tlast = '0;
        #1;
        total++;
        if (m_tvalid !== 1'b1 || m_tid !== 1'b1 || m_tdata !== 5'd7) begin
            bad++;
            $display("FAIL mid_out: got v=%0b tid=%0d data=%0d want v=1 tid=1 data=7", m_tvalid, m_tid, m_tdata);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_pkt_lock();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
